// File: rtl/ann_batch_sequencer.sv
// Batch initiator for the top_ann detection interface: walks an image address range,
// starts the ANN per image, decodes its seven-segment answer and tallies accuracy.
`timescale 1ns/1ps

module ann_batch_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        run,
  input  logic [9:0]  first_address,
  input  logic [10:0] num_images,
  input  logic [3:0]  expected_label,
  input  logic [7:0]  seven_seg,
  input  logic        done_processing,
  output logic        start_detecting,
  output logic [9:0]  image_address,
  output logic        busy,
  output logic        batch_done,
  output logic [3:0]  last_digit,
  output logic [10:0] correct_count,
  output logic [10:0] error_count,
  output logic        timeout_flag
);

  // The counter only has to reach TIMEOUT_CYCLES-1, so clog2 of the limit suffices.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_NEXT,
    S_DONE
  } state_e;

  state_e          state_q;
  logic            done_q;
  logic [TW-1:0]   tmo_q;
  logic [10:0]     remaining_q;
  logic [3:0]      digit_q;
  logic [3:0]      label_q;
  logic            done_edge;
  logic            capture_match;

  function automatic logic [3:0] decode_digit(input logic [6:0] seg);
    logic [3:0] digit;
    // NOTE: the default arm gives every code a value, so no latch is inferred.
    case (seg)
      7'h40:   digit = 4'd0;
      7'h79:   digit = 4'd1;
      7'h24:   digit = 4'd2;
      7'h30:   digit = 4'd3;
      7'h19:   digit = 4'd4;
      7'h12:   digit = 4'd5;
      7'h02:   digit = 4'd6;
      7'h78:   digit = 4'd7;
      7'h00:   digit = 4'd8;
      7'h10:   digit = 4'd9;
      default: digit = 4'hF;
    endcase
    return digit;
  endfunction

  // A done level already high when WAIT is entered is not an edge, since done_q tracks it.
  assign done_edge     = done_processing & ~done_q;
  assign capture_match = (digit_q <= 4'd9) && (digit_q == label_q);

  // NOTE: all state and outputs are updated with non-blocking assignments in one
  // clocked block, so every output is a register and there is no evaluation-order race.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q         <= S_IDLE;
      done_q          <= 1'b0;
      tmo_q           <= '0;
      remaining_q     <= '0;
      digit_q         <= '0;
      label_q         <= '0;
      start_detecting <= 1'b0;
      image_address   <= '0;
      busy            <= 1'b0;
      batch_done      <= 1'b0;
      last_digit      <= '0;
      correct_count   <= '0;
      error_count     <= '0;
      timeout_flag    <= 1'b0;
    end else begin
      done_q          <= done_processing;
      start_detecting <= 1'b0;
      batch_done      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (run) begin
            correct_count <= '0;
            error_count   <= '0;
            timeout_flag  <= 1'b0;
            busy          <= 1'b1;
            if (num_images != 11'd0) begin
              image_address   <= first_address;
              remaining_q     <= num_images;
              start_detecting <= 1'b1;
              state_q         <= S_ISSUE;
            end else begin
              batch_done <= 1'b1;
              state_q    <= S_DONE;
            end
          end
        end

        S_ISSUE: begin
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end

        S_WAIT: begin
          if (done_edge) begin
            digit_q <= decode_digit(seven_seg[6:0]);
            label_q <= expected_label;
            state_q <= S_CAPTURE;
          end else if (tmo_q == TMO_LAST) begin
            timeout_flag <= 1'b1;
            digit_q      <= 4'hE;
            state_q      <= S_CAPTURE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end

        S_CAPTURE: begin
          last_digit <= digit_q;
          if (capture_match) begin
            correct_count <= correct_count + 11'd1;
          end else begin
            error_count <= error_count + 11'd1;
          end
          remaining_q <= remaining_q - 11'd1;
          state_q     <= S_NEXT;
        end

        S_NEXT: begin
          if (remaining_q == 11'd0) begin
            batch_done <= 1'b1;
            state_q    <= S_DONE;
          end else begin
            // 10-bit address wraps from 1023 to 0 on its own.
            image_address   <= image_address + 10'd1;
            start_detecting <= 1'b1;
            state_q         <= S_ISSUE;
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ann_batch_sequencer.sv
// Directed bench for ann_batch_sequencer: the bench plays the ANN by hand, one step
// at a time, and compares outputs with hand-computed values.
`timescale 1ns/1ps

module tb_ann_batch_sequencer;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        run = 1'b0;
  logic [9:0]  first_address = '0;
  logic [10:0] num_images = '0;
  logic [3:0]  expected_label = '0;
  logic [7:0]  seven_seg = 8'hFF;
  logic        done_processing = 1'b0;
  logic        start_detecting;
  logic [9:0]  image_address;
  logic        busy;
  logic        batch_done;
  logic [3:0]  last_digit;
  logic [10:0] correct_count;
  logic [10:0] error_count;
  logic        timeout_flag;

  int vectors = 0;
  int miscompares = 0;
  int n_starts = 0;
  int n_batch_done = 0;
  int s0;
  int d0;

  ann_batch_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .run             (run),
    .first_address   (first_address),
    .num_images      (num_images),
    .expected_label  (expected_label),
    .seven_seg       (seven_seg),
    .done_processing (done_processing),
    .start_detecting (start_detecting),
    .image_address   (image_address),
    .busy            (busy),
    .batch_done      (batch_done),
    .last_digit      (last_digit),
    .correct_count   (correct_count),
    .error_count     (error_count),
    .timeout_flag    (timeout_flag)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start_detecting) n_starts++;
    if (batch_done) n_batch_done++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_batch(input logic [9:0] addr, input logic [10:0] num);
    first_address = addr;
    num_images    = num;
    run           = 1'b1;
    tick();
    run           = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (!start_detecting && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_start_seen"}, start_detecting, 1);
  endtask

  task automatic wait_batch_done(input string tag);
    int n = 0;
    while (!batch_done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_batch_done_seen"}, batch_done, 1);
  endtask

  // Plays one ANN transaction: start seen, 10 cycles of latency, one-cycle done pulse.
  task automatic serve_image(input string tag, input logic [9:0] addr,
                             input logic [3:0] label, input logic [7:0] seg);
    expected_label = label;
    wait_start(tag);
    check({tag, "_addr"}, image_address, addr);
    repeat (10) tick();
    seven_seg       = seg;
    done_processing = 1'b1;
    tick();
    done_processing = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_start", start_detecting, 0);
    check("rst_addr", image_address, 0);
    check("rst_busy", busy, 0);
    check("rst_batch_done", batch_done, 0);
    check("rst_last_digit", last_digit, 0);
    check("rst_correct", correct_count, 0);
    check("rst_error", error_count, 0);
    check("rst_timeout", timeout_flag, 0);
    n_reset = 1'b1;
    tick();

    // Single image at address 5, label 3, ANN answers 0x30 after 10 cycles
    start_batch(10'd5, 11'd1);
    check("t1_start", start_detecting, 1);
    check("t1_busy", busy, 1);
    check("t1_addr", image_address, 5);
    expected_label = 4'd3;
    tick();
    check("t1_start_one_cycle", start_detecting, 0);
    repeat (9) tick();
    seven_seg       = 8'h30;
    done_processing = 1'b1;
    tick();
    done_processing = 1'b0;
    check("t1_addr_in_capture", image_address, 5);
    check("t1_digit_not_yet", last_digit, 0);
    tick();
    check("t1_last_digit", last_digit, 3);
    check("t1_correct", correct_count, 1);
    check("t1_error", error_count, 0);
    tick();
    check("t1_batch_done", batch_done, 1);
    check("t1_busy_in_done", busy, 1);
    tick();
    check("t1_batch_done_one_cycle", batch_done, 0);
    check("t1_busy_low", busy, 0);
    check("t1_num_starts", n_starts, 1);
    check("t1_num_batch_done", n_batch_done, 1);

    // Address wrap 1022 -> 1023 -> 0 -> 1, all answers correct
    s0 = n_starts;
    start_batch(10'd1022, 11'd4);
    serve_image("t2a", 10'd1022, 4'd0, 8'h40);
    serve_image("t2b", 10'd1023, 4'd6, 8'h02);
    serve_image("t2c", 10'd0,    4'd8, 8'h00);
    serve_image("t2d", 10'd1,    4'd9, 8'h10);
    wait_batch_done("t2");
    check("t2_correct", correct_count, 4);
    check("t2_error", error_count, 0);
    check("t2_last_digit", last_digit, 9);
    check("t2_num_starts", n_starts - s0, 4);
    tick();
    check("t2_busy_low", busy, 0);

    // Mismatch, dp bit ignored, undecodable code
    start_batch(10'd100, 11'd3);
    check("t3_counts_cleared", correct_count, 0);
    serve_image("t3a", 10'd100, 4'd5, 8'h24);
    serve_image("t3b", 10'd101, 4'd7, 8'hF8);
    serve_image("t3c", 10'd102, 4'd2, 8'h7F);
    wait_batch_done("t3");
    check("t3_correct", correct_count, 1);
    check("t3_error", error_count, 2);
    check("t3_last_digit", last_digit, 4'hF);
    check("t3_timeout_flag", timeout_flag, 0);
    tick();

    // Timeout: ANN never answers; label 0xE must still count as an error
    expected_label  = 4'hE;
    done_processing = 1'b0;
    start_batch(10'd7, 11'd1);
    repeat (16) tick();
    check("t4_flag_not_early", timeout_flag, 0);
    tick();
    check("t4_flag_set", timeout_flag, 1);
    check("t4_error_before_capture", error_count, 0);
    tick();
    check("t4_last_digit", last_digit, 4'hE);
    check("t4_error", error_count, 1);
    check("t4_correct", correct_count, 0);
    tick();
    check("t4_batch_done", batch_done, 1);
    tick();

    // Zero-length batch: batch_done right away, no start pulse, stats cleared
    s0 = n_starts;
    d0 = n_batch_done;
    start_batch(10'd33, 11'd0);
    check("t6_batch_done", batch_done, 1);
    check("t6_busy", busy, 1);
    check("t6_no_start", start_detecting, 0);
    check("t6_timeout_cleared", timeout_flag, 0);
    check("t6_error_cleared", error_count, 0);
    tick();
    check("t6_batch_done_one_cycle", batch_done, 0);
    check("t6_busy_low", busy, 0);
    check("t6_num_starts", n_starts - s0, 0);
    check("t6_num_batch_done", n_batch_done - d0, 1);

    // Stale done held high through ISSUE, plus a run while busy
    s0 = n_starts;
    d0 = n_batch_done;
    done_processing = 1'b1;
    seven_seg       = 8'h19;
    expected_label  = 4'd4;
    start_batch(10'd200, 11'd1);
    check("t5_start", start_detecting, 1);
    tick();
    first_address = 10'd0;
    num_images    = 11'd0;
    run           = 1'b1;
    tick();
    run           = 1'b0;
    repeat (3) tick();
    check("t5_no_capture_digit", last_digit, 4'hE);
    check("t5_no_capture_correct", correct_count, 0);
    check("t5_no_capture_error", error_count, 0);
    check("t5_still_busy", busy, 1);
    check("t5_addr_kept", image_address, 200);
    done_processing = 1'b0;
    tick();
    done_processing = 1'b1;
    tick();
    done_processing = 1'b0;
    tick();
    check("t5_last_digit", last_digit, 4);
    check("t5_correct", correct_count, 1);
    wait_batch_done("t5");
    tick();
    check("t5_busy_low", busy, 0);
    repeat (3) tick();
    check("t5_num_starts", n_starts - s0, 1);
    check("t5_num_batch_done", n_batch_done - d0, 1);
    check("t5_addr_after", image_address, 200);

    // Reset during WAIT of the second image
    start_batch(10'd300, 11'd3);
    serve_image("t7a", 10'd300, 4'd1, 8'h79);
    wait_start("t7b");
    check("t7_pre_correct", correct_count, 1);
    check("t7_pre_last_digit", last_digit, 1);
    repeat (3) tick();
    d0 = n_batch_done;
    s0 = n_starts;
    #2;
    n_reset = 1'b0;
    #1;
    check("t7_rst_start", start_detecting, 0);
    check("t7_rst_addr", image_address, 0);
    check("t7_rst_busy", busy, 0);
    check("t7_rst_batch_done", batch_done, 0);
    check("t7_rst_last_digit", last_digit, 0);
    check("t7_rst_correct", correct_count, 0);
    check("t7_rst_error", error_count, 0);
    check("t7_rst_timeout", timeout_flag, 0);
    tick();
    n_reset = 1'b1;
    repeat (5) tick();
    check("t7_idle_busy", busy, 0);
    check("t7_no_batch_done", n_batch_done - d0, 0);
    check("t7_no_start", n_starts - s0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
